// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback grant encoding
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_wb_age_counter.sv
// rtl/regfile_wb_age_counter.sv - saturating refusal counter that flags a starved writeback source
module regfile_wb_age_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic frz,
    output logic sat
);

    localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] age;

    // Count refusals; freeze wins over clear so a held pipeline keeps its history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (!frz) begin
            if (clr) begin
                age <= '0;
            end else if (en && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
        end
    end

    assign sat = (age == AGE_MAX);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter with a registered regfile write stage
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              b_starved
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    gnt_e              gnt;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;
    logic              age_en;
    logic              age_clr;

    // Pick at most one winner: starved B first, then A, then B; hold blocks everything.
    always_comb begin
        gnt = GNT_NONE;
        if (!hold) begin
            if (b_starved && b_valid) begin
                gnt = GNT_B;
            end else if (a_valid) begin
                gnt = GNT_A;
            end else if (b_valid) begin
                gnt = GNT_B;
            end
        end
    end

    assign a_ready = (gnt == GNT_A);
    assign b_ready = (gnt == GNT_B);

    // Route the winner's destination and data towards the stage.
    always_comb begin
        win_reg  = a_reg;
        win_data = a_data;
        if (gnt == GNT_B) begin
            win_reg  = b_reg;
            win_data = b_data;
        end
    end

    // B ages while it waits unserved; any B transfer or B going idle resets its age.
    assign age_en  = b_valid && (gnt != GNT_B);
    assign age_clr = !b_valid || (gnt == GNT_B);

    regfile_wb_age_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_age (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (age_en),
        .clr   (age_clr),
        .frz   (hold),
        .sat   (b_starved)
    );

    // Stage the granted write; writes to $0 are consumed but never issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (gnt != GNT_NONE) begin
            wr_en   <= (win_reg != ZERO_REG);
            wr_reg  <= win_reg;
            wr_data <= win_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    assign fwd_valid = wr_en;
    assign fwd_reg   = wr_reg;
    assign fwd_data  = wr_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for the writeback arbiter
module tb_regfile_wb_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int MW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          hold = 1'b0;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_reg = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_reg = '0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic          fwd_valid;
    logic [AW-1:0] fwd_reg;
    logic [DW-1:0] fwd_data;
    logic          b_starved;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MAX_WAIT (MW),
        .CNT_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .fwd_valid (fwd_valid),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data),
        .b_starved (b_starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who wins, what is staged, how long B has waited.
    int            m_age = 0;
    logic          m_wr_en = 1'b0;
    logic [AW-1:0] m_wr_reg = '0;
    logic [DW-1:0] m_wr_data = '0;
    logic [DW-1:0] m_rf [32];
    logic [DW-1:0] rf [32];

    function automatic int winner(input logic h, input logic av, input logic bv, input int age);
        if (h) return 0;
        if (bv && age == MW) return 2;
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age     <= 0;
            m_wr_en   <= 1'b0;
            m_wr_reg  <= '0;
            m_wr_data <= '0;
        end else begin
            int g;
            g = winner(hold, a_valid, b_valid, m_age);
            if (m_wr_en) m_rf[m_wr_reg] <= m_wr_data;
            if (g == 1) begin
                m_wr_en <= (a_reg != 0); m_wr_reg <= a_reg; m_wr_data <= a_data;
            end else if (g == 2) begin
                m_wr_en <= (b_reg != 0); m_wr_reg <= b_reg; m_wr_data <= b_data;
            end else begin
                m_wr_en <= 1'b0;
            end
            if (!hold) begin
                if (!b_valid || g == 2) m_age <= 0;
                else if (m_age < MW) m_age <= m_age + 1;
            end
        end
    end

    // Regfile driven by the DUT's write port, used to see the final committed value.
    always @(posedge clk) begin
        if (wr_en) rf[wr_reg] <= wr_data;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int g;
        g = winner(hold, a_valid, b_valid, m_age);
        chk("a_ready",   {31'd0, a_ready},   {31'd0, g == 1});
        chk("b_ready",   {31'd0, b_ready},   {31'd0, g == 2});
        chk("b_starved", {31'd0, b_starved}, {31'd0, m_age == MW});
        chk("wr_en",     {31'd0, wr_en},     {31'd0, m_wr_en});
        chk("wr_reg",    {27'd0, wr_reg},    {27'd0, m_wr_reg});
        chk("wr_data",   wr_data,            m_wr_data);
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_wr_en});
        chk("fwd_reg",   {27'd0, fwd_reg},   {27'd0, m_wr_reg});
        chk("fwd_data",  fwd_data,           m_wr_data);
    end

    task automatic drive(input logic h, input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd);
        hold = h; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a_cnt;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
        chk("rst_wr_reg",    {27'd0, wr_reg},    32'd0);
        chk("rst_wr_data",   wr_data,            32'd0);
        chk("rst_b_starved", {31'd0, b_starved}, 32'd0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // 1: A only
        drive(0, 1, 5'd3, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        #2 chk("t1_a_ready", {31'd0, a_ready}, 32'd1);
        tick;
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("t1_wr_en",    {31'd0, wr_en},    32'd1);
        chk("t1_wr_reg",   {27'd0, wr_reg},   32'd3);
        chk("t1_wr_data",  wr_data,           32'hDEAD_BEEF);
        chk("t1_fwd_data", fwd_data,          32'hDEAD_BEEF);
        tick;

        // 2: both valid for 6 cycles
        a_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 5'd1, 32'd10 + 32'(i), 1, 5'd2, 32'd100);
            #2;
            if (i < 4 && a_ready) a_cnt++;
            if (i == 4) begin
                chk("t2_starved", {31'd0, b_starved}, 32'd1);
                chk("t2_b_grant", {31'd0, b_ready},   32'd1);
            end
            tick;
        end
        chk("t2_a_count", 32'(a_cnt), 32'd4);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick;

        // 3: write to $0
        drive(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'd5);
        #2 chk("t3_b_ready", {31'd0, b_ready}, 32'd1);
        tick;
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("t3_wr_en", {31'd0, wr_en}, 32'd0);
        tick;

        // 4: hold for 3 cycles with both valid, B already aged by one
        drive(0, 1, 5'd4, 32'd44, 1, 5'd5, 32'd55);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd4, 32'd45, 1, 5'd5, 32'd55);
            #2;
            chk("t4_a_ready", {31'd0, a_ready}, 32'd0);
            chk("t4_b_ready", {31'd0, b_ready}, 32'd0);
            if (i > 0) chk("t4_wr_en", {31'd0, wr_en}, 32'd0);
            tick;
        end
        drive(0, 1, 5'd4, 32'd45, 1, 5'd5, 32'd55);
        #2 chk("t4_release_a", {31'd0, a_ready}, 32'd1);
        tick;
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick;

        // 5: asynchronous reset mid-burst while a write is staged and B is starved
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'd9, 32'd900 + 32'(i), 1, 5'd10, 32'd1000);
            tick;
        end
        #2;
        chk("t5_pre_wr_en",   {31'd0, wr_en},     32'd1);
        chk("t5_pre_starved", {31'd0, b_starved}, 32'd1);
        rst_n = 1'b0;
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        chk("t5_wr_en",   {31'd0, wr_en},     32'd0);
        chk("t5_wr_reg",  {27'd0, wr_reg},    32'd0);
        chk("t5_wr_data", wr_data,            32'd0);
        chk("t5_starved", {31'd0, b_starved}, 32'd0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("t5_post_wr_en", {31'd0, wr_en}, 32'd0);
        tick;

        // 6: same-register collision
        drive(0, 1, 5'd7, 32'd1, 1, 5'd7, 32'd2);
        tick;
        drive(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'd2);
        chk("t6_first", wr_data, 32'd1);
        tick;
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("t6_second", wr_data, 32'd2);
        tick; tick;
        chk("t6_rf7",       rf[7],   32'd2);
        chk("t6_model_rf7", m_rf[7], 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
